// File: rtl/hit_judge_scorer.sv
// Chord judge and scorer: synchronises frets and strum, debounces the strum, judges each
// latched chord inside a timing window and keeps combo, multiplier and a saturating score.
module hit_judge_scorer #(
  parameter int unsigned LANES             = 5,
  parameter int unsigned DEBOUNCE          = 4,
  parameter int unsigned WINDOW_CYC        = 10,
  parameter int unsigned BASE_PTS          = 50,
  parameter int unsigned COMBO_STEP        = 10,
  parameter int unsigned MAX_MULT          = 4,
  parameter int unsigned SCORE_W           = 21,
  parameter int unsigned COMBO_W           = 10,
  parameter int unsigned OVERSTRUM_PENALTY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stop,
  input  logic               pause,
  input  logic [LANES-1:0]   buttons,
  input  logic               strum,
  input  logic               note_valid,
  input  logic [LANES-1:0]   notes_to_play,
  output logic               note_hit,
  output logic               note_miss,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         multiplier,
  output logic [SCORE_W-1:0] score,
  output logic [LANES-1:0]   lane_led
);

  localparam int unsigned WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned SUM_W = SCORE_W + 16;
  localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  typedef enum logic {IDLE, WINDOW} state_t;

  logic [LANES-1:0] btn_meta, btn_sync;
  logic             strum_meta, strum_sync, strum_db, strum_evt;
  logic [DB_W-1:0]  db_cnt;

  state_t           state, nxt_state;
  logic [LANES-1:0] chord, nxt_chord;
  logic [WIN_W-1:0] win_cnt, nxt_win;
  logic             new_chord, judge_hit, judge_miss;

  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [COMBO_W-1:0] combo_inc, combo_q;
  logic [2:0]         mult_next;

  // Synchronisers and strum debouncer; these keep running through pause and stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta   <= '0;
      btn_sync   <= '0;
      strum_meta <= 1'b0;
      strum_sync <= 1'b0;
      strum_db   <= 1'b0;
      strum_evt  <= 1'b0;
      db_cnt     <= '0;
    end else begin
      btn_meta   <= buttons;
      btn_sync   <= btn_meta;
      strum_meta <= strum;
      strum_sync <= strum_meta;
      strum_evt  <= 1'b0;
      if (strum_sync == strum_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        strum_db  <= strum_sync;
        db_cnt    <= '0;
        strum_evt <= strum_sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // A strum judges the old chord first; a new chord in the same cycle is still latched.
  always_comb begin
    new_chord  = note_valid && (notes_to_play != '0);
    judge_hit  = 1'b0;
    judge_miss = 1'b0;
    nxt_state  = state;
    nxt_chord  = chord;
    nxt_win    = win_cnt;
    if (state == IDLE) begin
      if (strum_evt && (OVERSTRUM_PENALTY != 0)) judge_miss = 1'b1;
    end else begin
      if (strum_evt) begin
        if (btn_sync == chord) judge_hit = 1'b1;
        else                   judge_miss = 1'b1;
        nxt_state = IDLE;
      end else if (new_chord) begin
        judge_miss = 1'b1;
      end else if (win_cnt == '0) begin
        judge_miss = 1'b1;
        nxt_state  = IDLE;
      end else begin
        nxt_win = win_cnt - 1'b1;
      end
    end
    if (new_chord) begin
      nxt_state = WINDOW;
      nxt_chord = notes_to_play;
      nxt_win   = WIN_W'(WINDOW_CYC - 1);
    end
  end

  assign score_sum = SUM_W'(score) + SUM_W'(BASE_PTS) * SUM_W'(multiplier);
  assign score_sat = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
  assign combo_inc = (combo == '1) ? combo : combo + 1'b1;
  assign combo_q   = combo / COMBO_W'(COMBO_STEP);
  assign mult_next = (combo_q >= COMBO_W'(MAX_MULT - 1)) ? 3'(MAX_MULT) : 3'(combo_q + 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      chord      <= '0;
      win_cnt    <= '0;
      note_hit   <= 1'b0;
      note_miss  <= 1'b0;
      combo      <= '0;
      score      <= '0;
      multiplier <= 3'd1;
    end else begin
      note_hit   <= 1'b0;
      note_miss  <= 1'b0;
      multiplier <= mult_next;
      if (stop) begin
        state      <= IDLE;
        chord      <= '0;
        win_cnt    <= '0;
        combo      <= '0;
        score      <= '0;
        multiplier <= 3'd1;
      end else if (!pause) begin
        state     <= nxt_state;
        chord     <= nxt_chord;
        win_cnt   <= nxt_win;
        note_hit  <= judge_hit;
        note_miss <= judge_miss;
        if (judge_hit) begin
          combo <= combo_inc;
          score <= score_sat;
        end else if (judge_miss) begin
          combo <= '0;
        end
      end
    end
  end

  assign lane_led = (state == WINDOW) ? chord : '0;

endmodule

// File: tb/tb_hit_judge_scorer.sv
// Randomised bench for hit_judge_scorer against a rule-level score/combo model.
module tb_hit_judge_scorer;

  logic       clk = 1'b0;
  logic       reset_n, stop, pause, strum, note_valid;
  logic [4:0] buttons, notes_to_play;

  logic       hit_a, miss_a, hit_b, miss_b, hit_c, miss_c;
  logic [9:0] combo_a, combo_b, combo_c;
  logic [2:0] mult_a, mult_b, mult_c;
  logic [20:0] score_a, score_b;
  logic [7:0] score_c;
  logic [4:0] led_a, led_b, led_c;

  hit_judge_scorer dut (
    .clk(clk), .reset_n(reset_n), .stop(stop), .pause(pause), .buttons(buttons), .strum(strum),
    .note_valid(note_valid), .notes_to_play(notes_to_play), .note_hit(hit_a), .note_miss(miss_a),
    .combo(combo_a), .multiplier(mult_a), .score(score_a), .lane_led(led_a));

  hit_judge_scorer #(.OVERSTRUM_PENALTY(0)) dut_np (
    .clk(clk), .reset_n(reset_n), .stop(stop), .pause(pause), .buttons(buttons), .strum(strum),
    .note_valid(note_valid), .notes_to_play(notes_to_play), .note_hit(hit_b), .note_miss(miss_b),
    .combo(combo_b), .multiplier(mult_b), .score(score_b), .lane_led(led_b));

  hit_judge_scorer #(.SCORE_W(8)) dut_s8 (
    .clk(clk), .reset_n(reset_n), .stop(stop), .pause(pause), .buttons(buttons), .strum(strum),
    .note_valid(note_valid), .notes_to_play(notes_to_play), .note_hit(hit_c), .note_miss(miss_c),
    .combo(combo_c), .multiplier(mult_c), .score(score_c), .lane_led(led_c));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_hit[3], n_miss[3];
  int both_err = 0;
  int m_score, m_score8, m_combo, m_mult;

  initial begin
    for (int i = 0; i < 3; i++) begin n_hit[i] = 0; n_miss[i] = 0; end
  end

  always @(negedge clk) begin
    if (hit_a)  n_hit[0]++;
    if (miss_a) n_miss[0]++;
    if (hit_b)  n_hit[1]++;
    if (miss_b) n_miss[1]++;
    if (hit_c)  n_hit[2]++;
    if (miss_c) n_miss[2]++;
    if ((hit_a && miss_a) || (hit_b && miss_b) || (hit_c && miss_c)) both_err++;
  end

  function automatic int mult_of(int c);
    return (1 + c / 10 > 4) ? 4 : 1 + c / 10;
  endfunction

  task automatic model_hit();
    m_score  = m_score + 50 * m_mult;
    if (m_score > 2097151) m_score = 2097151;
    m_score8 = m_score8 + 50 * m_mult;
    if (m_score8 > 255) m_score8 = 255;
    m_combo  = (m_combo < 1023) ? m_combo + 1 : 1023;
    m_mult   = mult_of(m_combo);
  endtask

  task automatic model_miss();
    m_combo = 0;
    m_mult  = 1;
  endtask

  task automatic model_clear();
    m_score = 0; m_score8 = 0; m_combo = 0; m_mult = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [4:0] ch);
    notes_to_play = ch;
    note_valid    = 1'b1;
    tick();
    note_valid    = 1'b0;
    notes_to_play = '0;
  endtask

  task automatic do_strum(input int len);
    strum = 1'b1;
    repeat (len) tick();
    strum = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (led_a !== 5'd0 || mult_a !== 3'd1) begin failures++; $display("FAIL reset_hold led=%0h mult=%0d exp led=0 mult=1", led_a, mult_a); end
    reset_n = 1'b1;
    tick();
    checks++; if (score_a !== 21'd0 || combo_a !== 10'd0) begin failures++; $display("FAIL reset_regs score=%0d combo=%0d exp 0 0", score_a, combo_a); end
    checks++; if (mult_a !== 3'd1) begin failures++; $display("FAIL reset_mult got=%0d exp=1", mult_a); end
    checks++; if (hit_a !== 1'b0 || miss_a !== 1'b0) begin failures++; $display("FAIL reset_pulses hit=%0b miss=%0b exp 0 0", hit_a, miss_a); end
    model_clear();
  endtask

  task automatic test_hit();
    int h0, m0;
    h0 = n_hit[0]; m0 = n_miss[0];
    buttons = 5'b00101;
    latch(5'b00101);
    checks++; if (led_a !== 5'b00101) begin failures++; $display("FAIL hit_led_window got=%b exp=00101", led_a); end
    do_strum(6);
    model_hit();
    checks++; if (n_hit[0] - h0 !== 1 || n_miss[0] - m0 !== 0) begin failures++; $display("FAIL hit_pulses hits=%0d misses=%0d exp 1 0", n_hit[0] - h0, n_miss[0] - m0); end
    checks++; if (score_a !== 21'd50 || score_a !== 21'(m_score)) begin failures++; $display("FAIL hit_score got=%0d exp=%0d", score_a, m_score); end
    checks++; if (combo_a !== 10'd1) begin failures++; $display("FAIL hit_combo got=%0d exp=1", combo_a); end
    checks++; if (led_a !== 5'd0) begin failures++; $display("FAIL hit_led_after got=%b exp=0", led_a); end
  endtask

  task automatic test_mismatch_timeout();
    int h0, m0, at;
    h0 = n_hit[0]; m0 = n_miss[0];
    buttons = 5'b00111;
    latch(5'b00101);
    do_strum(6);
    model_miss();
    checks++; if (n_miss[0] - m0 !== 1 || n_hit[0] - h0 !== 0) begin failures++; $display("FAIL mismatch_pulses misses=%0d hits=%0d exp 1 0", n_miss[0] - m0, n_hit[0] - h0); end
    checks++; if (combo_a !== 10'd0) begin failures++; $display("FAIL mismatch_combo got=%0d exp=0", combo_a); end
    latch(5'($urandom_range(1, 31)));
    at = 0;
    for (int k = 1; k <= 20 && at == 0; k++) begin
      tick();
      if (miss_a) at = k;
    end
    model_miss();
    checks++; if (at !== 10) begin failures++; $display("FAIL timeout_cycles got=%0d exp=10 (0 means no miss seen)", at); end
    checks++; if (led_a !== 5'd0) begin failures++; $display("FAIL timeout_led got=%b exp=0", led_a); end
    repeat (2) tick();
  endtask

  task automatic test_replace();
    logic [4:0] a, b;
    int h0;
    a = 5'($urandom_range(1, 31));
    b = 5'($urandom_range(1, 31));
    latch(a);
    repeat (2) tick();
    latch(b);
    model_miss();
    checks++; if (miss_a !== 1'b1 || hit_a !== 1'b0) begin failures++; $display("FAIL replace_old_miss miss=%0b hit=%0b exp 1 0", miss_a, hit_a); end
    checks++; if (led_a !== b) begin failures++; $display("FAIL replace_led got=%b exp=%b", led_a, b); end
    h0 = n_hit[0];
    buttons = b;
    do_strum(5);
    model_hit();
    checks++; if (n_hit[0] - h0 !== 1 || score_a !== 21'(m_score) || combo_a !== 10'(m_combo)) begin failures++; $display("FAIL replace_new_hit hits=%0d score=%0d combo=%0d exp 1 %0d %0d", n_hit[0] - h0, score_a, combo_a, m_score, m_combo); end
  endtask

  task automatic test_multiplier();
    logic [4:0] ch;
    stop = 1'b1; tick(); stop = 1'b0; tick();
    model_clear();
    checks++; if (score_a !== 21'd0 || combo_a !== 10'd0 || mult_a !== 3'd1) begin failures++; $display("FAIL mult_stop_clear score=%0d combo=%0d mult=%0d exp 0 0 1", score_a, combo_a, mult_a); end
    for (int n = 1; n <= 41; n++) begin
      ch = 5'($urandom_range(1, 31));
      buttons = ch;
      latch(ch);
      do_strum(5);
      model_hit();
      if (n == 10) begin
        checks++; if (score_a !== 21'd500 || mult_a !== 3'd2) begin failures++; $display("FAIL mult_ten_hits score=%0d mult=%0d exp 500 2", score_a, mult_a); end
      end
      if (n == 11) begin
        checks++; if (score_a !== 21'd600 || score_a !== 21'(m_score)) begin failures++; $display("FAIL mult_eleventh score=%0d exp=600", score_a); end
      end
    end
    checks++; if (mult_a !== 3'd4 || mult_a !== 3'(m_mult)) begin failures++; $display("FAIL mult_ceiling got=%0d exp=4", mult_a); end
    checks++; if (score_a !== 21'(m_score) || combo_a !== 10'(m_combo)) begin failures++; $display("FAIL mult_totals score=%0d combo=%0d exp %0d %0d", score_a, combo_a, m_score, m_combo); end
    checks++; if (score_c !== 8'd255 || score_c !== 8'(m_score8)) begin failures++; $display("FAIL score_saturate8 got=%0d exp=255", score_c); end
  endtask

  task automatic test_random();
    logic [4:0] ch;
    bit want_hit;
    int h0, m0;
    for (int n = 0; n < 20; n++) begin
      ch = 5'($urandom_range(1, 31));
      want_hit = ($urandom_range(0, 2) != 0);
      buttons = want_hit ? ch : (ch ^ 5'($urandom_range(1, 31)));
      h0 = n_hit[0]; m0 = n_miss[0];
      latch(ch);
      do_strum(4 + $urandom_range(0, 2));
      if (want_hit) model_hit(); else model_miss();
      checks++;
      if (n_hit[0] - h0 !== int'(want_hit) || n_miss[0] - m0 !== int'(!want_hit)) begin
        failures++; $display("FAIL random_pulse n=%0d hits=%0d misses=%0d exp_hit=%0b", n, n_hit[0] - h0, n_miss[0] - m0, want_hit);
      end
      checks++;
      if (score_a !== 21'(m_score) || combo_a !== 10'(m_combo) || mult_a !== 3'(m_mult)) begin
        failures++; $display("FAIL random_state n=%0d score=%0d combo=%0d mult=%0d exp %0d %0d %0d", n, score_a, combo_a, mult_a, m_score, m_combo, m_mult);
      end
    end
  endtask

  task automatic test_debounce_overstrum();
    int h[3], m[3];
    for (int i = 0; i < 3; i++) begin h[i] = n_hit[i]; m[i] = n_miss[i]; end
    strum = 1'b1; repeat (3) tick(); strum = 1'b0; repeat (10) tick();
    checks++;
    if (n_hit[0] != h[0] || n_miss[0] != m[0] || n_miss[1] != m[1] || n_miss[2] != m[2]) begin
      failures++; $display("FAIL glitch_no_event misses a/b/c=%0d/%0d/%0d exp 0/0/0", n_miss[0] - m[0], n_miss[1] - m[1], n_miss[2] - m[2]);
    end
    do_strum(5);
    model_miss();
    checks++; if (n_miss[0] - m[0] !== 1 || n_miss[2] - m[2] !== 1) begin failures++; $display("FAIL overstrum_miss a=%0d c=%0d exp 1 1", n_miss[0] - m[0], n_miss[2] - m[2]); end
    checks++; if (n_miss[1] - m[1] !== 0 || n_hit[1] - h[1] !== 0) begin failures++; $display("FAIL overstrum_nopenalty misses=%0d hits=%0d exp 0 0", n_miss[1] - m[1], n_hit[1] - h[1]); end
    checks++; if (combo_a !== 10'd0) begin failures++; $display("FAIL overstrum_combo got=%0d exp=0", combo_a); end
  endtask

  task automatic test_pause();
    logic [4:0] ch;
    int m0, h0, at;
    ch = 5'($urandom_range(1, 31));
    buttons = ch;
    latch(ch);
    repeat (3) tick();
    m0 = n_miss[0]; h0 = n_hit[0];
    pause = 1'b1;
    strum = 1'b1;
    repeat (5) tick();
    strum = 1'b0;
    repeat (45) tick();
    checks++; if (n_miss[0] != m0 || n_hit[0] != h0) begin failures++; $display("FAIL pause_no_pulse misses=%0d hits=%0d exp 0 0", n_miss[0] - m0, n_hit[0] - h0); end
    checks++; if (led_a !== ch) begin failures++; $display("FAIL pause_led got=%b exp=%b", led_a, ch); end
    pause = 1'b0;
    at = 0;
    for (int k = 1; k <= 20 && at == 0; k++) begin
      tick();
      if (miss_a) at = k;
    end
    model_miss();
    checks++; if (at !== 10 - 3) begin failures++; $display("FAIL pause_resume_cycles got=%0d exp=7", at); end
    repeat (2) tick();
  endtask

  task automatic test_stop();
    logic [4:0] ch;
    int m0;
    ch = 5'($urandom_range(1, 31));
    buttons = ch;
    latch(ch);
    do_strum(5);
    model_hit();
    checks++; if (score_a !== 21'(m_score) || score_a === 21'd0) begin failures++; $display("FAIL stop_pre_score got=%0d exp=%0d", score_a, m_score); end
    latch(ch);
    pause = 1'b1; stop = 1'b1;
    tick();
    pause = 1'b0; stop = 1'b0;
    model_clear();
    checks++; if (score_a !== 21'd0 || combo_a !== 10'd0 || mult_a !== 3'd1) begin failures++; $display("FAIL stop_clear score=%0d combo=%0d mult=%0d exp 0 0 1", score_a, combo_a, mult_a); end
    checks++; if (led_a !== 5'd0 || hit_a !== 1'b0 || miss_a !== 1'b0) begin failures++; $display("FAIL stop_idle led=%b hit=%0b miss=%0b exp 0 0 0", led_a, hit_a, miss_a); end
    m0 = n_miss[0];
    repeat (15) tick();
    checks++; if (n_miss[0] != m0) begin failures++; $display("FAIL stop_no_timeout misses=%0d exp=0", n_miss[0] - m0); end
  endtask

  task automatic test_reset_mid_window();
    logic [4:0] ch;
    ch = 5'($urandom_range(1, 31));
    buttons = ch;
    latch(ch);
    do_strum(5);
    model_hit();
    latch(ch);
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (score_a !== 21'd0 || combo_a !== 10'd0 || mult_a !== 3'd1 || led_a !== 5'd0) begin failures++; $display("FAIL async_reset score=%0d combo=%0d mult=%0d led=%b exp 0 0 1 0", score_a, combo_a, mult_a, led_a); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
    tick();
  endtask

  initial begin
    reset_n = 1'b0; stop = 1'b0; pause = 1'b0; strum = 1'b0;
    note_valid = 1'b0; buttons = '0; notes_to_play = '0;
    model_clear();
    test_reset();
    test_hit();
    test_mismatch_timeout();
    test_replace();
    test_multiplier();
    test_random();
    test_debounce_overstrum();
    test_pause();
    test_stop();
    test_reset_mid_window();
    checks++; if (both_err !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d cycles with hit and miss exp=0", both_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim time expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/hit_judge_scorer.md
Name: hit_judge_scorer

Overview:
Parametrised successor to the gameplay/scoring pair. Judges each chord reaching the strike line against the fretted buttons and a debounced strum, inside a programmable timing window. Keeps a combo streak, a score multiplier and a saturating score. Sits between drop_notes (chord source) and bcd_converter/HEX_Display (score sink).

Parameters:
LANES, 5, number of fret lanes
DEBOUNCE, 4, consecutive stable cycles before the synchronised strum is accepted
WINDOW_CYC, 10, cycles a latched chord stays hittable
BASE_PTS, 50, points per hit before the multiplier is applied
COMBO_STEP, 10, hits per multiplier increment
MAX_MULT, 4, multiplier ceiling (1..7)
SCORE_W, 21, score width
COMBO_W, 10, combo width
OVERSTRUM_PENALTY, 1, 1 = a strum with no open window counts as a miss

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
stop  in  1  synchronous clear (score, combo, FSM)
pause  in  1  freeze judging
buttons  in  LANES  raw fret buttons (async)
strum  in  1  raw strum bar (async)
note_valid  in  1  one-cycle pulse: new chord at strike line
notes_to_play  in  LANES  chord, valid with note_valid
note_hit  out  1  one-cycle hit pulse
note_miss  out  1  one-cycle miss pulse
combo  out  COMBO_W  current streak
multiplier  out  3  current multiplier
score  out  SCORE_W  accumulated score
lane_led  out  LANES  latched chord while WINDOW, else 0

Behaviour:
- Reset (async, reset_n=0): all registers 0 except multiplier=1. FSM goes to IDLE. note_hit, note_miss and lane_led are 0.
- buttons and strum each pass through a 2-flop synchroniser.
- Strum debounce: the debounced value takes the synchronised value after DEBOUNCE consecutive equal cycles. strum_evt is a one-cycle pulse on the debounced 0->1 edge. The debouncer keeps running during pause.
- FSM states: IDLE, WINDOW.
  - IDLE, note_valid with notes_to_play != 0: latch chord, load win_cnt = WINDOW_CYC-1, go to WINDOW.
  - note_valid with an all-zero chord: ignored.
  - WINDOW, strum_evt with synced buttons == latched chord: hit, go to IDLE.
  - WINDOW, strum_evt with any mismatch (including extra frets): miss, go to IDLE.
  - WINDOW, no strum_evt: win_cnt decrements. A miss is raised in the cycle win_cnt==0, then go to IDLE. The window is exactly WINDOW_CYC cycles.
  - WINDOW, note_valid: the current chord is judged miss. The new chord is latched and win_cnt reloaded, staying in WINDOW. If strum_evt lands in the same cycle, it judges the old chord, and the new chord is still latched.
  - IDLE, strum_evt: miss if OVERSTRUM_PENALTY=1, else ignored.
- Pulses are registered. note_hit/note_miss assert the cycle after the judging event; never both at once.
- Combo and score are updated in the same cycle as the pulse.
  - Hit: score += BASE_PTS*multiplier, using the multiplier value before the update. Score saturates at 2^SCORE_W-1. Combo += 1, saturating at all-ones.
  - Miss: combo <= 0. Score is unchanged.
  - multiplier = min(1 + combo/COMBO_STEP, MAX_MULT), registered from the updated combo. It is therefore valid one cycle after the pulse.
- pause=1: FSM, win_cnt, combo and score hold. strum_evt and note_valid are discarded, and no pulses are produced. lane_led holds.
- stop=1: synchronous clear of score, combo, multiplier(=1) and FSM(IDLE). stop takes priority over pause and any event in the same cycle. No pulse is produced that cycle.

Test Plan:
- Reset mid-WINDOW (reset_n low one cycle) -> score=0, combo=0, multiplier=1, lane_led=0 immediately, without waiting for a clock edge.
- Hit: note_valid with chord 5'b00101, buttons=00101, strum high ≥6 cycles -> single note_hit, score=50, combo=1, lane_led=0.
- Mismatch and timeout: same chord, buttons=00111, strum -> note_miss, combo=0. Next chord with no strum -> note_miss exactly 10 cycles after latch.
- Multiplier: 10 consecutive hits -> score=500, multiplier=2. 11th hit -> score=600. After 30 more hits: multiplier stays 4.
- Debounce and overstrum: 3-cycle strum glitch -> no event. A 5-cycle strum in IDLE -> note_miss. The same with OVERSTRUM_PENALTY=0 -> nothing.
- Pause, stop, saturation:
  - Pause during WINDOW for 50 cycles -> no miss; the window resumes with its remaining count.
  - stop with pause high -> score=0.
  - SCORE_W=8 with repeated hits -> score sticks at 255.
